// File: rtl/lab7_pkg.sv
// Shared constants, types and the LFSR feedback function for the computer
// player's random number source.
package lab7_pkg;

  localparam int RNG_WIDTH = 10;

  typedef logic [RNG_WIDTH-1:0] rng_t;

  localparam rng_t RNG_DEFAULT_SEED = 10'h001;
  // Taps at bits 9 and 6: x^10 + x^7 + 1, maximal length (period 1023).
  localparam rng_t RNG_DEFAULT_TAPS = 10'h240;

  // One Fibonacci shift: feedback is the parity of the tapped bits, entering at bit 0.
  function automatic rng_t lfsr_next(rng_t state, rng_t taps);
    return {state[RNG_WIDTH-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_rng.sv
// lfsr_rng: 10-bit maximal-length Fibonacci LFSR advanced by a step strobe.
// Seed load has priority over step; a zero seed is replaced by SEED so the
// all-zero lock-up state can never be entered. wrap pulses when a step
// returns the state to the value it started from (reset or last load).
// Optional build macro LFSR_STEP_COUNT_EN adds a step_count output; the wrap
// decision is then taken from that counter instead of the start-value compare.
module lfsr_rng
  import lab7_pkg::*;
#(
  parameter int   WIDTH = RNG_WIDTH,
  parameter rng_t SEED  = RNG_DEFAULT_SEED,
  parameter rng_t TAPS  = RNG_DEFAULT_TAPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             step,
`ifdef LFSR_STEP_COUNT_EN
  output logic [WIDTH-1:0] step_count,
`endif
  output logic [WIDTH-1:0] rand_out,
  output logic             valid,
  output logic             wrap
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic             valid_q, valid_d;
  logic             wrap_q,  wrap_d;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] load_value;
  logic             wrap_hit;

  assign next_state = WIDTH'(lfsr_next(rng_t'(state_q), TAPS));
  assign load_value = (seed_in == '0) ? WIDTH'(SEED) : seed_in;

`ifdef LFSR_STEP_COUNT_EN
  // Last count value of a period; the step taking the counter past it closes the cycle.
  localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'((2 ** WIDTH) - 2);

  logic [WIDTH-1:0] count_q, count_d;

  assign wrap_hit = (count_q == LAST_COUNT);

  // Steps accepted since reset/load, modulo the LFSR period.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (step) begin
      count_d = wrap_hit ? '0 : count_q + 1'b1;
    end
  end

  // Step counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign step_count = count_q;
`else
  assign wrap_hit = (next_state == start_q);
`endif

  // Next-state selection: load beats step, otherwise hold.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    if (load) begin
      state_d = load_value;
      start_d = load_value;
      valid_d = 1'b1;
    end else if (step) begin
      state_d = next_state;
      valid_d = 1'b1;
      wrap_d  = wrap_hit;
    end
  end

  // State, start value and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WIDTH'(SEED);
      start_q <= WIDTH'(SEED);
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign rand_out = state_q;
  assign valid    = valid_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed plus randomized bench for lfsr_rng against a period-counting model.
module tb_lfsr_rng;

  localparam int W      = 10;
  localparam int PERIOD = 1023;

  logic         clk;
  logic         reset;
  logic         load;
  logic [W-1:0] seed_in;
  logic         step;
  logic [W-1:0] rand_out;
  logic         valid;
  logic         wrap;
`ifdef LFSR_STEP_COUNT_EN
  logic [W-1:0] step_count;
`endif

  lfsr_rng dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .seed_in  (seed_in),
    .step     (step),
`ifdef LFSR_STEP_COUNT_EN
    .step_count(step_count),
`endif
    .rand_out (rand_out),
    .valid    (valid),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: value plus number of steps taken since the last reset/load.
  int m_state;
  int m_steps;
  bit m_valid;
  bit m_wrap;

  function automatic int model_next(int s);
    int fb;
    fb = ((s / 512) % 2) ^ ((s / 64) % 2);
    return ((s * 2) % 1024) + fb;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 1;
    m_steps = 0;
    m_valid = 0;
    m_wrap  = 0;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".rand_out"}, int'(rand_out), m_state);
    chk({tag, ".valid"}, int'(valid), int'(m_valid));
    chk({tag, ".wrap"}, int'(wrap), int'(m_wrap));
`ifdef LFSR_STEP_COUNT_EN
    chk({tag, ".step_count"}, int'(step_count), m_steps % PERIOD);
`endif
  endtask

  // Apply one cycle of inputs, advance the model, check after the edge.
  task automatic cycle(bit ld, int sd, bit st, string tag);
    load    = ld;
    seed_in = W'(sd);
    step    = st;
    @(posedge clk);
    if (ld) begin
      m_state = (sd == 0) ? 1 : sd;
      m_steps = 0;
      m_valid = 1;
      m_wrap  = 0;
    end else if (st) begin
      m_state = model_next(m_state);
      m_steps++;
      m_valid = 1;
      m_wrap  = (m_steps % PERIOD) == 0;
    end else begin
      m_wrap = 0;
    end
    #1;
    check_all(tag);
  endtask

  int  exp_seq [7] = '{'h002, 'h004, 'h008, 'h010, 'h020, 'h040, 'h081};
  bit  seen [1024];
  int  distinct;
  int  held;
  int  rseed;

  initial begin
    reset = 1'b0; load = 1'b0; seed_in = '0; step = 1'b1;
    model_reset();

    // Reset held with step active: nothing moves.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all("reset_hold");
    end

    // Release between edges; idle cycles must not change anything.
    @(negedge clk);
    step  = 1'b0;
    reset = 1'b1;
    cycle(0, 0, 0, "post_release");
    cycle(0, 0, 0, "post_release");

    // First seven steps from the reset seed.
    for (int i = 0; i < 7; i++) begin
      cycle(0, 0, 1, "step_seq");
      chk("step_seq_const", int'(rand_out), exp_seq[i]);
    end

    // Fresh reset, then a full period of continuous stepping.
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_all("reset_again");
    @(negedge clk);
    reset = 1'b1;
    foreach (seen[i]) seen[i] = 0;
    distinct = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      cycle(0, 0, 1, "period");
      if (!seen[rand_out] && rand_out != 0) distinct++;
      seen[rand_out] = 1;
    end
    chk("period_distinct", distinct, PERIOD);
    chk("period_end_value", int'(rand_out), 1);
    chk("period_end_wrap", int'(wrap), 1);
    cycle(0, 0, 1, "after_wrap");
    chk("after_wrap_low", int'(wrap), 0);

    // Load beats step; zero seed is substituted.
    cycle(1, 'h155, 1, "load_priority");
    chk("load_priority_const", int'(rand_out), 'h155);
    cycle(1, 0, 0, "load_zero");
    chk("load_zero_const", int'(rand_out), 'h001);
    cycle(1, 'h155, 0, "load_again");
    for (int i = 1; i <= PERIOD + 5; i++) cycle(0, 0, 1, "after_load");

    // Hold for ten cycles.
    held = int'(rand_out);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, "hold");
    chk("hold_stable", int'(rand_out), held);

    // Randomized load/step mix, including occasional zero seeds.
    rseed = 0;
    for (int i = 0; i < 2500; i++) begin
      bit ld, st;
      int sd;
      ld = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 3) != 0);
      sd = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 1023));
      cycle(ld, sd, st, "random");
    end

    // Asynchronous reset dropped mid-cycle takes effect before the next edge.
    cycle(1, 'h2a3, 0, "pre_async");
    cycle(0, 0, 1, "pre_async");
    @(negedge clk);
    step  = 1'b1;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_rand_out", int'(rand_out), 1);
    chk("async_valid", int'(valid), 0);
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b1;
    cycle(0, 0, 1, "after_async");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
- Pseudo-random number source for the computer player.
- 10-bit maximal-length Fibonacci LFSR; advances only on a step strobe, so the value changes once per decision tick.
- rand_out drives the B input of comparator; the switch value drives A.
- Supports seed load and flags sequence wrap, so play can be reproduced and verified deterministically.

Parameters:
- WIDTH, 10, state and output width in bits.
- SEED, 10'h001, reset value; also used as the substitute when a zero seed is loaded. Must be nonzero.
- TAPS, 10'h240, feedback mask (bits 9 and 6; polynomial x^10+x^7+1). feedback = XOR-reduce(state & TAPS).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low; 0 = reset asserted.
- load  input  1  seed load strobe, sampled on clk.
- seed_in  input  WIDTH  seed value, used when load=1.
- step  input  1  advance strobe, one LFSR shift per cycle in which it is high.
- rand_out  output  WIDTH  current LFSR state, registered.
- valid  output  1  high once the state has been loaded or stepped at least once since reset.
- wrap  output  1  one-cycle pulse when a step returns the state to its start value.

Behaviour:
- Reset (reset=0, asynchronous):
  - state and rand_out = SEED; start register = SEED; valid = 0; wrap = 0.
  - Takes effect immediately; a load or step in progress is discarded.
- Release is synchronous to clk. The first active edge follows the rules below.
- Shift rule: next = {state[WIDTH-2:0], feedback}.
- Per-edge priority, evaluated at each rising edge with reset=1:
  - load=1: state = (seed_in==0) ? SEED : seed_in; start register = same value; valid = 1; wrap = 0. step is ignored that cycle (load wins).
  - load=0, step=1: state = next; valid = 1; wrap = 1 only if next == start register, else 0.
  - Both 0: state holds; wrap = 0; valid holds.
- Latency: rand_out shows the new value the cycle after the strobe edge (one register, no extra pipeline).
- Period: 2^WIDTH-1 = 1023 steps. wrap pulses on step 1023, 2046, ... after a load or reset.
- All-zero state is unreachable: the reset value is nonzero, a zero seed is substituted, and the shift preserves nonzero states.
- step held high continuously: one shift per cycle, free-running. wrap behaviour is unchanged.
- wrap is never high for two consecutive cycles, because the period is greater than 1.

Optional Feature:
- Macro: LFSR_STEP_COUNT_EN.
- Defined:
  - Adds output step_count [WIDTH] (register).
  - Cleared to 0 on reset and on load.
  - Increments on each accepted step.
  - Wraps from 1022 to 0 on the same edge that asserts wrap.
  - The wrap decision then comes from the counter (count==1022 while stepping) rather than the state compare. Both must agree; the bench checks this.
- Undefined: port and counter absent; wrap comes from the start-register compare only.

Decomposition:
- Package lab7_pkg:
  - constants RNG_WIDTH=10, RNG_DEFAULT_SEED=10'h001, RNG_DEFAULT_TAPS=10'h240
  - typedef rng_t (logic [RNG_WIDTH-1:0])
  - function lfsr_next(rng_t state, rng_t taps) returning the shifted value.
- No sub-module. The feedback function is pure combinational logic and lives in the package; the block is a single module.

Test Plan:
- Reset check: hold reset=0 with step=1 for 3 cycles → rand_out=0x001, valid=0, wrap=0 throughout; after release, no change until the first edge with step=1.
- Step sequence from reset: 7 consecutive step pulses → rand_out = 0x002, 0x004, 0x008, 0x010, 0x020, 0x040, 0x081; valid=1 from the first step.
- Full period: step held high for 1023 cycles → all 1023 values distinct, none zero; rand_out=0x001 after step 1023 with wrap=1 for exactly that cycle. With LFSR_STEP_COUNT_EN, step_count=0 on the same cycle.
- Load priority and zero-seed substitution:
  - load=1, step=1, seed_in=0x155 → rand_out=0x155 (no shift).
  - load=1, seed_in=0 → rand_out=0x001.
  - Afterwards, wrap occurs 1023 steps after each load.
- Hold and asynchronous reset mid-run:
  - step=0 for 10 cycles → rand_out stable.
  - Drop reset between edges mid-sequence → rand_out=0x001 and valid=0 before the next edge.
